// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Each operation takes 34 edges: operand capture, 32 radix-2 steps, sign fix-up.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        dbz,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
        logic [31:0] result;
        if (is_signed && value[31]) begin
            result = 32'd0 - value;
        end else begin
            result = value;
        end
        return result;
    endfunction

    function automatic logic [31:0] negate32(input logic [31:0] value, input logic do_neg);
        logic [31:0] result;
        if (do_neg) begin
            result = 32'd0 - value;
        end else begin
            result = value;
        end
        return result;
    endfunction

    function automatic logic [63:0] negate64(input logic [63:0] value, input logic do_neg);
        logic [63:0] result;
        if (do_neg) begin
            result = 64'd0 - value;
        end else begin
            result = value;
        end
        return result;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic        busy_r;
    logic        busy_s;
    logic        done_r;
    logic        done_s;
    logic        dbz_r;
    logic        dbz_s;
    logic        capture_s;
    logic        step_s;
    logic        fix_s;

    logic [1:0]  op_r;
    logic [31:0] a_raw_r;
    logic [31:0] mag_a_r;
    logic [31:0] mag_b_r;
    logic        neg_a_r;
    logic        neg_b_r;
    logic [4:0]  cnt_r;
    logic [32:0] hi_acc_r;
    logic [31:0] lo_acc_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        cap_signed_s;
    logic [31:0] cap_mag_a_s;
    logic [31:0] cap_mag_b_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_shift_s;
    logic [33:0] div_diff_s;
    logic [32:0] hi_step_s;
    logic [31:0] lo_step_s;
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] hi_res_s;
    logic [31:0] lo_res_s;
    logic        dbz_res_s;

    // Next-state and control decode for the IDLE/ITER/FIX sequencer.
    always_comb begin
        state_s   = state_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        capture_s = 1'b0;
        step_s    = 1'b0;
        fix_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s   = ST_ITER;
                    capture_s = 1'b1;
                    busy_s    = 1'b1;
                end else begin
                    state_s   = ST_IDLE;
                    busy_s    = 1'b0;
                end
            end
            ST_ITER: begin
                step_s = 1'b1;
                busy_s = 1'b1;
                if (cnt_r == 5'd31) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_ITER;
                end
            end
            ST_FIX: begin
                fix_s   = 1'b1;
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
        dbz_s = fix_s & dbz_res_s;
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            dbz_r   <= dbz_s;
        end
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        cap_signed_s = ~op[0];
        cap_mag_a_s  = magnitude(A, cap_signed_s);
        cap_mag_b_s  = magnitude(B, cap_signed_s);
        mul_sum_s    = lo_acc_r[0] ? (hi_acc_r + {1'b0, mag_a_r}) : hi_acc_r;
        div_shift_s  = {hi_acc_r[31:0], lo_acc_r[31]};
        div_diff_s   = {1'b0, div_shift_s} - {2'b00, mag_b_r};
        if (op_r[1]) begin
            if (div_diff_s[33]) begin
                hi_step_s = div_shift_s;
                lo_step_s = {lo_acc_r[30:0], 1'b0};
            end else begin
                hi_step_s = div_diff_s[32:0];
                lo_step_s = {lo_acc_r[30:0], 1'b1};
            end
        end else begin
            hi_step_s = {1'b0, mul_sum_s[32:1]};
            lo_step_s = {mul_sum_s[0], lo_acc_r[31:1]};
        end
    end

    // Sign fix-up of the unsigned magnitude result, plus the divide-by-zero override.
    always_comb begin
        prod_s = negate64({hi_acc_r[31:0], lo_acc_r}, ~op_r[0] & (neg_a_r ^ neg_b_r));
        quo_s  = negate32(lo_acc_r, ~op_r[0] & (neg_a_r ^ neg_b_r));
        rem_s  = negate32(hi_acc_r[31:0], ~op_r[0] & neg_a_r);
        if (!op_r[1]) begin
            hi_res_s  = prod_s[63:32];
            lo_res_s  = prod_s[31:0];
            dbz_res_s = 1'b0;
        end else if (mag_b_r == 32'd0) begin
            hi_res_s  = a_raw_r;
            lo_res_s  = 32'hFFFF_FFFF;
            dbz_res_s = 1'b1;
        end else begin
            hi_res_s  = rem_s;
            lo_res_s  = quo_s;
            dbz_res_s = 1'b0;
        end
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= 2'b00;
            a_raw_r  <= 32'd0;
            mag_a_r  <= 32'd0;
            mag_b_r  <= 32'd0;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            cnt_r    <= 5'd0;
            hi_acc_r <= 33'd0;
            lo_acc_r <= 32'd0;
        end else if (capture_s) begin
            op_r     <= op;
            a_raw_r  <= A;
            mag_a_r  <= cap_mag_a_s;
            mag_b_r  <= cap_mag_b_s;
            neg_a_r  <= cap_signed_s & A[31];
            neg_b_r  <= cap_signed_s & B[31];
            cnt_r    <= 5'd0;
            hi_acc_r <= 33'd0;
            lo_acc_r <= op[1] ? cap_mag_a_s : cap_mag_b_s;
        end else if (step_s) begin
            hi_acc_r <= hi_step_s;
            lo_acc_r <= lo_step_s;
            cnt_r    <= cnt_r + 5'd1;
        end else begin
            cnt_r    <= cnt_r;
            hi_acc_r <= hi_acc_r;
            lo_acc_r <= lo_acc_r;
        end
    end

    // HI/LO: result write on fix-up, software writes only while not busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (fix_s) begin
            hi_r <= hi_res_s;
            lo_r <= lo_res_s;
        end else begin
            if (hi_we && !busy_r) begin
                hi_r <= wdata;
            end
            if (lo_we && !busy_r) begin
                lo_r <= wdata;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign dbz  = dbz_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] HI;
    logic [31:0] LO;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: ordinary 64-bit arithmetic on the architectural operands.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic z);
        longint      sa;
        longint      sb;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        z  = 1'b0;
        hi = 32'd0;
        lo = 32'd0;
        if (o[1] && b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            z  = 1'b1;
        end else begin
            case (o)
                2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
                2'b01: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
                2'b10: begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
                default: begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
            endcase
        end
    endfunction

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic whi, input logic wlo, input logic [31:0] wd);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; op = o; A = a; B = b;
        hi_we = whi; lo_we = wlo; wdata = wd;
        model(o, a, b, exp_hi, exp_lo, exp_dbz);
        @(posedge clk); #1;
        if (whi) cur_hi = wd;
        if (wlo) cur_lo = wd;
        check("e0_busy", busy, 1);
        check("e0_done", done, 0);
        check("e0_hi", HI, cur_hi);
        check("e0_lo", LO, cur_lo);
    endtask

    // Runs edges E1..E33; at edge k (if nonzero) injects start + HI/LO writes that must be ignored.
    task automatic wait_done(input string tag, input int k);
        logic early;
        logic unstable;
        early = 1'b0;
        unstable = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            op = 2'($urandom); A = $urandom; B = $urandom; wdata = $urandom;
            if (i == k) begin
                start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_DEAD;
            end
            @(posedge clk); #1;
            if (i < 33) begin
                if (done !== 1'b0 || dbz !== 1'b0 || busy !== 1'b1) early = 1'b1;
                if (HI !== cur_hi || LO !== cur_lo) unstable = 1'b1;
            end
        end
        check({tag, "_no_early"}, early, 0);
        check({tag, "_stable"}, unstable, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dbz"}, dbz, exp_dbz);
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
        cur_hi = exp_hi;
        cur_lo = exp_lo;
    endtask

    task automatic check_after(input string tag);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        @(posedge clk); #1;
        check({tag, "_post"}, {busy, done, dbz}, 3'b000);
        check({tag, "_post_hilo"}, {HI, LO}, {cur_hi, cur_lo});
    endtask

    task automatic mt(input logic whi, input logic wlo, input logic [31:0] wd);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; hi_we = whi; lo_we = wlo; wdata = wd;
        @(posedge clk); #1;
        if (whi) cur_hi = wd;
        if (wlo) cur_lo = wd;
        check("mt_hilo", {HI, LO}, {cur_hi, cur_lo});
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    initial begin
        logic        quiet;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
        op = 2'b00; A = 32'd5; B = 32'd7; wdata = 32'hA5A5_A5A5;
        cur_hi = 32'd0; cur_lo = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_status", {busy, done, dbz}, 3'b000);
        check("rst_hilo", {HI, LO}, 64'd0);

        mt(1'b1, 1'b0, 32'h1111_2222);
        mt(1'b0, 1'b1, 32'h3333_4444);

        start_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'd0);
        wait_done("mult_neg2x3", 0);
        check("mult_neg2x3_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        check_after("mult_neg2x3");

        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        wait_done("multu_max", 0);
        check("multu_max_const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);

        start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0);
        wait_done("div_neg7", 0);
        check("div_neg7_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

        start_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0);
        wait_done("divu_big", 0);
        check("divu_big_const", {HI, LO}, 64'h0000_0001_7FFF_FFFC);

        start_op(2'b11, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 32'd0);
        wait_done("divu_zero", 0);
        check("divu_zero_const", {dbz, HI, LO}, {1'b1, 64'h0000_1234_FFFF_FFFF});
        check_after("divu_zero");

        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        wait_done("div_ovf", 0);
        check("div_ovf_const", {dbz, HI, LO}, {1'b0, 64'h0000_0000_8000_0000});

        start_op(2'b00, 32'd1234, 32'hFFFF_F000, 1'b0, 1'b0, 32'd0);
        wait_done("mult_interfere", 5);
        check_after("mult_interfere");

        start_op(2'b01, 32'd77, 32'd9, 1'b1, 1'b1, 32'hCAFE_F00D);
        wait_done("e0_write", 0);
        start_op(2'b10, 32'd100, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0);
        wait_done("back_to_back", 0);
        check_after("back_to_back");

        start_op(2'b10, 32'h0BAD_F00D, 32'd17, 1'b0, 1'b0, 32'd0);
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        cur_hi = 32'd0; cur_lo = 32'd0;
        check("midrst_status", {busy, done, dbz}, 3'b000);
        check("midrst_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) quiet = 1'b0;
        end
        check("midrst_quiet", quiet, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        start_op(2'b10, 32'h0BAD_F00D, 32'd17, 1'b0, 1'b0, 32'd0);
        wait_done("after_rst", 0);

        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            start_op(ro, ra, rb, 1'($urandom), 1'($urandom), $urandom);
            wait_done("rand", $urandom_range(0, 33));
            check_after("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
